// File: rtl/lsu_multicycle_if.sv
// lsu_multicycle_if: request/response and word-aligned memory port of the load/store unit.
interface lsu_multicycle_if #(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_fault;
    logic              resp_misaligned;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_write_data;
    logic [XLEN-1:0]   mem_read_data;
    logic              mem_valid;
    modport slave (
        input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
               mem_read_data, mem_valid,
        output req_ready, resp_valid, resp_rdata, resp_fault, resp_misaligned, busy,
               mem_address, mem_read_enable, mem_write_enable, mem_wstrb, mem_write_data
    );
    modport master (
        output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
               mem_read_data, mem_valid,
        input  req_ready, resp_valid, resp_rdata, resp_fault, resp_misaligned, busy,
               mem_address, mem_read_enable, mem_write_enable, mem_wstrb, mem_write_data
    );
endinterface

// File: rtl/lsu_multicycle.sv
// lsu_multicycle: one-at-a-time handshaked load/store unit with byte strobes, extension and timeout.
module lsu_multicycle #(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic clock,
    input logic reset,
    lsu_multicycle_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] MAX_SIZE = 2'(OFF_W);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESP} state_t;
    state_t            state_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, wr_q, valid_q, fault_q, mis_q;
    logic [NB-1:0]     strb_q;
    logic [XLEN-1:0]   wdata_q, rdata_q;
    logic [OFF_W-1:0]  req_off;
    logic              illegal, misaligned, sign, timeout;
    logic [2:0]        amask;
    logic [7:0]        bmask;
    logic [NB-1:0]     strb_d;
    logic [XLEN-1:0]   wdata_d, shifted, keep, top, rdata_d;
    assign req_off = bus.req_addr[OFF_W-1:0];
    assign illegal = bus.req_size > MAX_SIZE;
    assign amask = 3'((4'd1 << bus.req_size) - 4'd1);
    assign misaligned = |(bus.req_addr[2:0] & amask);
    assign bmask = bus.req_size == 2'd0 ? 8'h01 :
                   bus.req_size == 2'd1 ? 8'h03 :
                   bus.req_size == 2'd2 ? 8'h0F : 8'hFF;
    assign strb_d = NB'(bmask) << req_off;
    assign wdata_d = bus.req_wdata << {req_off, 3'b000};
    // keep masks the 8<<size result bits; its top set bit selects the sign bit
    assign shifted = bus.mem_read_data >> {off_q, 3'b000};
    assign keep = ~({XLEN{1'b1}} << (7'd8 << size_q));
    assign top = keep & ~(keep >> 1);
    assign sign = ~uns_q & |(shifted & top);
    assign rdata_d = (shifted & keep) | ({XLEN{sign}} & ~keep);
    assign timeout = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    off_q  <= req_off;
                    size_q <= bus.req_size;
                    uns_q  <= bus.req_unsigned;
                    cnt_q  <= '0;
                    if (illegal) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        fault_q <= 1'b1;
                    end else if (misaligned) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        mis_q   <= 1'b1;
                    end else begin
                        addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        strb_q  <= strb_d;
                        wdata_q <= wdata_d;
                        rd_q    <= ~bus.req_is_store;
                        wr_q    <= bus.req_is_store;
                        state_q <= bus.req_is_store ? WRITE_WAIT : READ_WAIT;
                    end
                end
                READ_WAIT, WRITE_WAIT: if (bus.mem_valid || timeout) begin
                    state_q <= RESP;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    valid_q <= 1'b1;
                    fault_q <= ~bus.mem_valid;
                    rdata_q <= (bus.mem_valid && state_q == READ_WAIT) ? rdata_d : '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                    mis_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end
    assign bus.req_ready        = state_q == IDLE;
    assign bus.busy             = state_q != IDLE;
    assign bus.resp_valid       = valid_q;
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_fault       = fault_q;
    assign bus.resp_misaligned  = mis_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_read_enable  = rd_q;
    assign bus.mem_write_enable = wr_q;
    assign bus.mem_wstrb        = strb_q;
    assign bus.mem_write_data   = wdata_q;
endmodule

// File: tb/tb_lsu_multicycle.sv
// tb_lsu_multicycle: directed checks of lsu_multicycle at XLEN=32, XLEN=64 and a short timeout.
module tb_lsu_multicycle;
    logic clock, reset;
    int total, bad;
    int n_en, at;
    logic f;
    logic [31:0] rd;
    lsu_multicycle_if #(.XLEN(32), .ADDR_W(32)) i32 ();
    lsu_multicycle_if #(.XLEN(32), .ADDR_W(32)) it4 ();
    lsu_multicycle_if #(.XLEN(64), .ADDR_W(32)) i64 ();
    lsu_multicycle #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(16)) u32 (.clock(clock), .reset(reset), .bus(i32.slave));
    lsu_multicycle #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) ut4 (.clock(clock), .reset(reset), .bus(it4.slave));
    lsu_multicycle #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(16)) u64 (.clock(clock), .reset(reset), .bus(i64.slave));
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic req32(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] wd);
        i32.req_valid = 1'b1;
        i32.req_is_store = st;
        i32.req_size = sz;
        i32.req_unsigned = un;
        i32.req_addr = a;
        i32.req_wdata = wd;
        @(negedge clock);
        i32.req_valid = 1'b0;
    endtask
    task automatic req4(input logic [1:0] sz, input logic [31:0] a);
        it4.req_valid = 1'b1;
        it4.req_is_store = 1'b0;
        it4.req_size = sz;
        it4.req_unsigned = 1'b0;
        it4.req_addr = a;
        it4.req_wdata = '0;
        @(negedge clock);
        it4.req_valid = 1'b0;
    endtask
    task automatic req64(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [63:0] wd);
        i64.req_valid = 1'b1;
        i64.req_is_store = st;
        i64.req_size = sz;
        i64.req_unsigned = un;
        i64.req_addr = a;
        i64.req_wdata = wd;
        @(negedge clock);
        i64.req_valid = 1'b0;
    endtask
    task automatic mem64(input logic [63:0] d);
        i64.mem_valid = 1'b1;
        i64.mem_read_data = d;
        @(negedge clock);
        i64.mem_valid = 1'b0;
    endtask
    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        {i32.req_valid, i32.req_is_store, i32.req_size, i32.req_unsigned, i32.req_addr, i32.req_wdata, i32.mem_read_data, i32.mem_valid} = '0;
        {it4.req_valid, it4.req_is_store, it4.req_size, it4.req_unsigned, it4.req_addr, it4.req_wdata, it4.mem_read_data, it4.mem_valid} = '0;
        {i64.req_valid, i64.req_is_store, i64.req_size, i64.req_unsigned, i64.req_addr, i64.req_wdata, i64.mem_read_data, i64.mem_valid} = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", i32.req_ready, 1);
        chk("rst_busy", i32.busy, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", i32.req_ready, 1);
        chk("idle_outs", {i32.resp_valid, i32.mem_read_enable, i32.mem_write_enable, i32.mem_wstrb, i32.mem_address}, 0);
        // LB 0x103: sign-extended top byte
        req32(0, 0, 0, 32'h103, 0);
        chk("lb_ren", i32.mem_read_enable, 1);
        chk("lb_addr", i32.mem_address, 32'h100);
        chk("lb_busy", {i32.busy, i32.req_ready, i32.resp_valid}, 3'b100);
        i32.mem_valid = 1'b1;
        i32.mem_read_data = 32'h80AA_BBCC;
        @(negedge clock);
        i32.mem_valid = 1'b0;
        chk("lb_rv", i32.resp_valid, 1);
        chk("lb_rdata", i32.resp_rdata, 32'hFFFF_FF80);
        chk("lb_flags", {i32.resp_fault, i32.resp_misaligned, i32.mem_read_enable}, 0);
        @(negedge clock);
        chk("lb_idle", {i32.resp_valid, i32.req_ready}, 2'b01);
        req32(0, 0, 1, 32'h103, 0);
        i32.mem_valid = 1'b1;
        @(negedge clock);
        i32.mem_valid = 1'b0;
        chk("lbu_rdata", i32.resp_rdata, 32'h0000_0080);
        @(negedge clock);
        // SH 0x202 with five stall cycles
        req32(1, 1, 0, 32'h202, 32'h0000_BEEF);
        i32.req_wdata = 32'h1234_5678;
        chk("sh_strb", i32.mem_wstrb, 4'b1100);
        chk("sh_wdata", i32.mem_write_data, 32'hBEEF_0000);
        chk("sh_addr", i32.mem_address, 32'h200);
        for (int i = 0; i < 5; i++) begin
            chk("sh_hold", {i32.mem_write_enable, i32.mem_read_enable, i32.mem_wstrb, i32.mem_write_data, i32.resp_valid}, {2'b10, 4'b1100, 32'hBEEF_0000, 1'b0});
            @(negedge clock);
        end
        i32.mem_valid = 1'b1;
        i32.mem_read_data = 32'hDEAD_BEEF;
        @(negedge clock);
        i32.mem_valid = 1'b0;
        chk("sh_resp", {i32.resp_valid, i32.resp_fault, i32.mem_write_enable}, 3'b100);
        chk("sh_rdata", i32.resp_rdata, 0);
        @(negedge clock);
        // misaligned LW and illegal size
        req32(0, 2, 0, 32'h1002, 0);
        chk("lw_mis", {i32.resp_valid, i32.resp_misaligned, i32.resp_fault, i32.mem_read_enable, i32.req_ready}, 5'b11000);
        @(negedge clock);
        chk("lw_mis_idle", {i32.resp_valid, i32.req_ready}, 2'b01);
        req32(0, 3, 0, 32'h0, 0);
        chk("sz3_fault", {i32.resp_valid, i32.resp_misaligned, i32.resp_fault, i32.mem_read_enable}, 4'b1010);
        @(negedge clock);
        // timeout after 4 wait cycles
        it4.mem_read_data = 32'hDEAD_BEEF;
        req4(2, 32'h40);
        n_en = 0;
        at = 0;
        for (int i = 1; i <= 8; i++) begin
            if (it4.mem_read_enable) n_en++;
            if (it4.resp_valid && at == 0) begin
                at = i;
                f = it4.resp_fault;
                rd = it4.resp_rdata;
            end
            @(negedge clock);
        end
        chk("to_en_cycles", n_en, 4);
        chk("to_resp_at", at, 5);
        chk("to_fault", f, 1);
        chk("to_rdata", rd, 0);
        // mem_valid on the last wait cycle beats the timeout
        it4.mem_read_data = 32'h0000_7F00;
        req4(0, 32'h41);
        n_en = 0;
        at = 0;
        for (int i = 1; i <= 8; i++) begin
            if (it4.mem_read_enable) n_en++;
            if (it4.resp_valid && at == 0) begin
                at = i;
                f = it4.resp_fault;
                rd = it4.resp_rdata;
            end
            it4.mem_valid = (i == 4);
            @(negedge clock);
        end
        chk("race_en_cycles", n_en, 4);
        chk("race_resp_at", at, 5);
        chk("race_fault", f, 0);
        chk("race_rdata", rd, 32'h0000_007F);
        // XLEN=64
        req64(0, 3, 0, 32'h8, 0);
        chk("ld_addr", i64.mem_address, 32'h8);
        mem64(64'h8000_0000_0000_0001);
        chk("ld_rdata", i64.resp_rdata, 64'h8000_0000_0000_0001);
        @(negedge clock);
        req64(0, 2, 1, 32'hC, 0);
        chk("lwu_addr", i64.mem_address, 32'h8);
        mem64(64'hFFFF_FFFF_0000_0000);
        chk("lwu_rdata", i64.resp_rdata, 64'h0000_0000_FFFF_FFFF);
        @(negedge clock);
        req64(0, 2, 0, 32'hC, 0);
        mem64(64'hFFFF_FFFF_0000_0000);
        chk("lw64_rdata", i64.resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock);
        req64(1, 0, 0, 32'h7, 64'hA5);
        chk("sb_strb", i64.mem_wstrb, 8'h80);
        chk("sb_wdata", i64.mem_write_data, 64'hA500_0000_0000_0000);
        chk("sb_wen", i64.mem_write_enable, 1);
        mem64(64'h0);
        chk("sb_resp", {i64.resp_valid, i64.resp_fault, i64.resp_misaligned}, 3'b100);
        @(negedge clock);
        // reset while waiting, then stray mem_valid
        req32(0, 1, 0, 32'h10, 0);
        chk("rr_ren", i32.mem_read_enable, 1);
        #1 reset = 1'b1;
        #1;
        chk("rr_async", {i32.mem_read_enable, i32.req_ready, i32.busy, i32.mem_address}, {3'b010, 32'h0});
        @(negedge clock);
        reset = 1'b0;
        i32.mem_valid = 1'b1;
        i32.mem_read_data = 32'hFFFF_FFFF;
        @(negedge clock);
        i32.mem_valid = 1'b0;
        chk("rr_noresp", {i32.resp_valid, i32.busy, i32.req_ready, i32.mem_read_enable, i32.resp_rdata}, {4'b0010, 32'h0});
        @(negedge clock);
        chk("rr_still_idle", {i32.resp_valid, i32.req_ready}, 2'b01);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
